// File: rtl/pll_lock_seq_pkg.sv
// Shared types and sizing helpers for the PLL bring-up/supervision controller.
package pll_lock_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_LOCK,
    S_SETTLE,
    S_READY,
    S_FAULT
  } state_t;

  // Width of a counter that must reach (largest of the three limits - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_seq_chan.sv
// One supervised PLL channel: lock synchroniser, sequencing FSM, phase counter,
// retry bookkeeping and the dynamic-delay register.
module pll_lock_seq_chan
  import pll_lock_seq_pkg::*;
#(
  parameter int DELAY_W         = 8,
  parameter int RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int STABLE_CYCLES   = 256,
  parameter int MAX_RETRY       = 3,
  parameter bit BYPASS_ON_FAULT = 1'b1,
  parameter int RW              = $clog2(MAX_RETRY + 1)
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               enable,
  input  logic               pll_lock,
  input  logic [DELAY_W-1:0] delay_in,
  input  logic               delay_we,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic [DELAY_W-1:0] pll_dynamicdelay,
  output logic               ready,
  output logic               fault,
  output logic [RW-1:0]      retry_cnt
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RESET_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  state_t       state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [RW-1:0] retry, retry_nx;
  logic          lock_p0, lock_p1;
  logic          lock_s;
  logic          fail;

  assign lock_s = lock_p1;

  // Two-flop synchroniser for the asynchronous LOCK pin
  always_ff @(posedge clk) begin
    if (!resetb) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_p1 <= lock_p0;
    end
  end

  // Delay word loads on every strobe, whatever the sequencing state
  always_ff @(posedge clk) begin
    if (!resetb)       pll_dynamicdelay <= '0;
    else if (delay_we) pll_dynamicdelay <= delay_in;
  end

  // State, phase counter and retry registers
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= S_IDLE;
      cnt   <= '0;
      retry <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      retry <= retry_nx;
    end
  end

  // Next-state: ENABLE drop beats lock loss/timeout, which beats requalification
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    retry_nx = retry;
    fail     = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_HOLD;
          cnt_nx   = '0;
          retry_nx = '0;
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = S_SETTLE;
            cnt_nx   = '0;
          end else if (cnt == WAIT_LAST) begin
            fail = 1'b1;
          end
        end
        S_SETTLE: begin
          if (!lock_s) begin
            fail = 1'b1;
          end else if (delay_we) begin
            cnt_nx = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_nx = S_READY;
            cnt_nx   = '0;
            retry_nx = '0;
          end
        end
        S_READY: begin
          cnt_nx = '0;
          if (!lock_s) begin
            fail = 1'b1;
          end else if (delay_we) begin
            state_nx = S_SETTLE;
          end
        end
        S_FAULT: begin
          cnt_nx = '0;
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
      // Retry path: another reset attempt, or give up once the budget is spent
      if (fail) begin
        cnt_nx = '0;
        if (retry == RETRY_MAX) begin
          state_nx = S_FAULT;
        end else begin
          state_nx = S_HOLD;
          retry_nx = retry + RW'(1);
        end
      end
    end
  end

  assign pll_resetb = (state == S_WAIT_LOCK) || (state == S_SETTLE) || (state == S_READY);
  assign pll_bypass = BYPASS_ON_FAULT && (state == S_FAULT);
  assign ready      = (state == S_READY);
  assign fault      = (state == S_FAULT);
  assign retry_cnt  = retry;

endmodule

// File: rtl/pll_lock_seq.sv
// Multi-channel PLL bring-up and supervision controller: one independent
// sequencer per PLL plus a registered all-channels-ready flag.
module pll_lock_seq
  import pll_lock_seq_pkg::*;
#(
  parameter int NUM_PLL         = 2,
  parameter int DELAY_W         = 8,
  parameter int RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int STABLE_CYCLES   = 256,
  parameter int MAX_RETRY       = 3,
  parameter bit BYPASS_ON_FAULT = 1'b1
) (
  input  logic                                        CLK,
  input  logic                                        RESETB,
  input  logic [NUM_PLL-1:0]                          ENABLE,
  input  logic [NUM_PLL-1:0]                          PLL_LOCK,
  input  logic [NUM_PLL*DELAY_W-1:0]                  DELAY_IN,
  input  logic [NUM_PLL-1:0]                          DELAY_WE,
  output logic [NUM_PLL-1:0]                          PLL_RESETB,
  output logic [NUM_PLL-1:0]                          PLL_BYPASS,
  output logic [NUM_PLL*DELAY_W-1:0]                  PLL_DYNAMICDELAY,
  output logic [NUM_PLL-1:0]                          READY,
  output logic [NUM_PLL-1:0]                          FAULT,
  output logic [NUM_PLL*$clog2(MAX_RETRY+1)-1:0]      RETRY_CNT,
  output logic                                        ALL_READY
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_chan
    pll_lock_seq_chan #(
      .DELAY_W        (DELAY_W),
      .RESET_CYCLES   (RESET_CYCLES),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .MAX_RETRY      (MAX_RETRY),
      .BYPASS_ON_FAULT(BYPASS_ON_FAULT),
      .RW             (RW)
    ) u_chan (
      .clk             (CLK),
      .resetb          (RESETB),
      .enable          (ENABLE[i]),
      .pll_lock        (PLL_LOCK[i]),
      .delay_in        (DELAY_IN[i*DELAY_W +: DELAY_W]),
      .delay_we        (DELAY_WE[i]),
      .pll_resetb      (PLL_RESETB[i]),
      .pll_bypass      (PLL_BYPASS[i]),
      .pll_dynamicdelay(PLL_DYNAMICDELAY[i*DELAY_W +: DELAY_W]),
      .ready           (READY[i]),
      .fault           (FAULT[i]),
      .retry_cnt       (RETRY_CNT[i*RW +: RW])
    );
  end

  // All-ready flag, one cycle behind the last channel reaching READY
  always_ff @(posedge CLK) begin
    if (!RESETB) ALL_READY <= 1'b0;
    else         ALL_READY <= &READY;
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: directed bring-up/fault/lock-loss/delay/reset
// scenario with literal checkpoints, then a long randomized run, all checked
// every cycle against a countdown-based behavioural model.
module tb_pll_lock_seq;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int RC   = 4;
  localparam int LT   = 32;
  localparam int SC   = 8;
  localparam int MR   = 2;
  localparam int RW   = $clog2(MR + 1);
  localparam int NRND = 12000;

  logic              clk;
  logic              rstb;
  logic [N-1:0]      en, lock, we;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      pll_rstb, pll_byp, rdy, flt;
  logic [N*DW-1:0]   dly;
  logic [N*RW-1:0]   rcnt;
  logic              all_rdy;

  pll_lock_seq #(
    .NUM_PLL(N), .DELAY_W(DW), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC), .MAX_RETRY(MR), .BYPASS_ON_FAULT(1'b1)
  ) dut (
    .CLK(clk), .RESETB(rstb), .ENABLE(en), .PLL_LOCK(lock),
    .DELAY_IN(din), .DELAY_WE(we), .PLL_RESETB(pll_rstb),
    .PLL_BYPASS(pll_byp), .PLL_DYNAMICDELAY(dly), .READY(rdy),
    .FAULT(flt), .RETRY_CNT(rcnt), .ALL_READY(all_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 off, 1 reset pulse, 2 awaiting lock, 3 qualifying,
  // 4 locked, 5 given up. 'left' counts cycles remaining in a timed phase.
  int          phase [N];
  int          left  [N];
  int          tries [N];
  bit          seen0 [N];
  bit          seen1 [N];
  logic [DW-1:0] mdly [N];
  bit          mall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ls, lost;
    if (!rstb) begin
      mall = 1'b0;
      for (int c = 0; c < N; c++) begin
        phase[c] = 0; left[c] = 0; tries[c] = 0;
        seen0[c] = 1'b0; seen1[c] = 1'b0; mdly[c] = '0;
      end
    end else begin
      mall = 1'b1;
      for (int c = 0; c < N; c++) if (phase[c] != 4) mall = 1'b0;
      for (int c = 0; c < N; c++) begin
        ls = seen1[c];
        seen1[c] = seen0[c];
        seen0[c] = lock[c];
        lost = 1'b0;
        if (we[c]) mdly[c] = din[c*DW +: DW];
        if (!en[c]) begin
          phase[c] = 0;
          tries[c] = 0;
        end else begin
          case (phase[c])
            0: begin phase[c] = 1; left[c] = RC; tries[c] = 0; end
            1: begin
              left[c]--;
              if (left[c] == 0) begin phase[c] = 2; left[c] = LT; end
            end
            2: begin
              if (ls) begin phase[c] = 3; left[c] = SC; end
              else begin left[c]--; if (left[c] == 0) lost = 1'b1; end
            end
            3: begin
              if (!ls) lost = 1'b1;
              else if (we[c]) left[c] = SC;
              else begin
                left[c]--;
                if (left[c] == 0) begin phase[c] = 4; tries[c] = 0; end
              end
            end
            4: begin
              if (!ls) lost = 1'b1;
              else if (we[c]) begin phase[c] = 3; left[c] = SC; end
            end
            default: ;
          endcase
          if (lost) begin
            if (tries[c] == MR) phase[c] = 5;
            else begin tries[c]++; phase[c] = 1; left[c] = RC; end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]    e_rstb, e_byp, e_rdy, e_flt;
    logic [N*DW-1:0] e_dly;
    logic [N*RW-1:0] e_rc;
    for (int c = 0; c < N; c++) begin
      e_rstb[c] = (phase[c] == 2) || (phase[c] == 3) || (phase[c] == 4);
      e_byp[c]  = (phase[c] == 5);
      e_rdy[c]  = (phase[c] == 4);
      e_flt[c]  = (phase[c] == 5);
      e_dly[c*DW +: DW] = mdly[c];
      e_rc[c*RW +: RW]  = RW'(tries[c]);
    end
    chk("PLL_RESETB", 32'(pll_rstb), 32'(e_rstb));
    chk("PLL_BYPASS", 32'(pll_byp), 32'(e_byp));
    chk("READY", 32'(rdy), 32'(e_rdy));
    chk("FAULT", 32'(flt), 32'(e_flt));
    chk("PLL_DYNAMICDELAY", 32'(dly), 32'(e_dly));
    chk("RETRY_CNT", 32'(rcnt), 32'(e_rc));
    chk("ALL_READY", 32'(all_rdy), 32'(mall));
  endtask

  // Inputs are set before the edge, the model advances, outputs are checked mid-cycle
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic directed_inputs(input int s);
    rstb    = (s != 170);
    en[0]   = (s != 160);
    lock[0] = (s >= 10) && (s != 115) && !(s >= 158 && s <= 160);
    we[0]   = (s == 140) || (s == 160);
    din[DW-1:0] = (s == 140) ? 8'h5A : 8'h33;
    en[1]   = (s != 109);
    lock[1] = (s >= 110);
    we[1]   = 1'b0;
    din[2*DW-1:DW] = 8'h00;
  endtask

  task automatic literal_checks(input int s);
    logic [RW-1:0] r0, r1;
    logic [DW-1:0] d0;
    r0 = rcnt[RW-1:0];
    r1 = rcnt[2*RW-1:RW];
    d0 = dly[DW-1:0];
    case (s)
      3:   chk("bringup hold rstb0", 32'(pll_rstb[0]), 32'd0);
      4:   chk("bringup release rstb0", 32'(pll_rstb[0]), 32'd1);
      19:  chk("bringup not yet ready0", 32'(rdy[0]), 32'd0);
      20: begin
        chk("bringup ready0", 32'(rdy[0]), 32'd1);
        chk("bringup retry0", 32'(r0), 32'd0);
      end
      36: begin
        chk("timeout retry1", 32'(r1), 32'd1);
        chk("timeout rstb1", 32'(pll_rstb[1]), 32'd0);
      end
      107: chk("pre fault1", 32'(flt[1]), 32'd0);
      108: begin
        chk("fault1", 32'(flt[1]), 32'd1);
        chk("bypass1", 32'(pll_byp[1]), 32'd1);
        chk("fault retry1", 32'(r1), 32'd2);
        chk("ch0 unaffected", 32'(rdy[0]), 32'd1);
      end
      109: begin
        chk("fault cleared1", 32'(flt[1]), 32'd0);
        chk("bypass cleared1", 32'(pll_byp[1]), 32'd0);
      end
      116: chk("lockloss still ready0", 32'(rdy[0]), 32'd1);
      117: begin
        chk("lockloss ready0", 32'(rdy[0]), 32'd0);
        chk("lockloss retry0", 32'(r0), 32'd1);
        chk("lockloss rstb0", 32'(pll_rstb[0]), 32'd0);
      end
      121: chk("relock rstb0", 32'(pll_rstb[0]), 32'd1);
      130: begin
        chk("relock ready0", 32'(rdy[0]), 32'd1);
        chk("relock retry0", 32'(r0), 32'd0);
        chk("all_ready lag", 32'(all_rdy), 32'd0);
      end
      131: chk("all_ready", 32'(all_rdy), 32'd1);
      140: begin
        chk("delay load", 32'(d0), 32'h5A);
        chk("delay requal ready0", 32'(rdy[0]), 32'd0);
      end
      147: chk("delay requal still low", 32'(rdy[0]), 32'd0);
      148: begin
        chk("delay requal ready0", 32'(rdy[0]), 32'd1);
        chk("delay rstb0 held", 32'(pll_rstb[0]), 32'd1);
        chk("delay retry0", 32'(r0), 32'd0);
      end
      160: begin
        chk("simul idle rstb0", 32'(pll_rstb[0]), 32'd0);
        chk("simul delay", 32'(d0), 32'h33);
        chk("simul retry0", 32'(r0), 32'd0);
      end
      170: begin
        chk("reset ready", 32'(rdy), 32'd0);
        chk("reset delay", 32'(dly), 32'd0);
        chk("reset all_ready", 32'(all_rdy), 32'd0);
        chk("reset rstb", 32'(pll_rstb), 32'd0);
      end
      174: chk("restart hold rstb0", 32'(pll_rstb[0]), 32'd0);
      175: chk("restart wait rstb0", 32'(pll_rstb[0]), 32'd1);
      default: ;
    endcase
  endtask

  task automatic random_inputs();
    rstb = ($urandom_range(0, 2999) != 0);
    for (int c = 0; c < N; c++) begin
      if (en[c]) en[c] = ($urandom_range(0, 399) != 0);
      else       en[c] = ($urandom_range(0, 7) == 0);
      if (lock[c]) lock[c] = ($urandom_range(0, 299) != 0);
      else         lock[c] = ($urandom_range(0, 59) == 0);
      we[c] = ($urandom_range(0, 49) == 0);
      din[c*DW +: DW] = DW'($urandom);
    end
  endtask

  initial begin
    rstb = 1'b0;
    en   = '0;
    lock = '0;
    we   = '0;
    din  = '0;
    for (int i = 0; i < 3; i++) step();
    chk("reset rstb", 32'(pll_rstb), 32'd0);
    chk("reset retry", 32'(rcnt), 32'd0);
    for (int s = 0; s < 180; s++) begin
      directed_inputs(s);
      step();
      literal_checks(s);
    end
    for (int s = 0; s < NRND; s++) begin
      random_inputs();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
